dpe_pkt_arbiter: RTL and testbench

- Packet-level round-robin arbiter that merges five DPE stream sources onto one DPE stream sink: source 0 is the CPU FIFO, sources 1-4 are Ethernet RX ports 1-4.
- Sits in the sys_clk domain at the DPE ingress, ahead of the lookup/forwarding pipeline.
- A grant is held for a whole packet (tvalid..tlast) so packets never interleave.
- Per-source enable mask is driven from CSR.

---
 rtl/dpe_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 34 +++
 rtl/dpe_pkt_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_dpe_pkt_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpe_pkg.sv
// Shared DPE stream constants and types for the ingress arbiter and the egress schedulers.
package dpe_pkg;

   localparam int DPE_N_SRC  = 5;
   localparam int DPE_DATA_W = 64;
   localparam int DPE_KEEP_W = DPE_DATA_W / 8;

   typedef logic [2:0] dpe_src_t;

   localparam dpe_src_t SRC_CPU  = 3'd0;
   localparam dpe_src_t SRC_ETH1 = 3'd1;
   localparam dpe_src_t SRC_ETH2 = 3'd2;
   localparam dpe_src_t SRC_ETH3 = 3'd3;
   localparam dpe_src_t SRC_ETH4 = 3'd4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_XFER = 1'b1
   } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester after 'last', wrapping modulo N_SRC.
module rr_arbiter
   import dpe_pkg::*;
#(
   parameter int N_SRC = DPE_N_SRC
) (
   input  logic [N_SRC-1:0] req,
   input  logic [2:0]       last,
   output logic [2:0]       gnt_idx,
   output logic             gnt_vld
);

   logic [3:0] base;

   always_comb begin
      logic [3:0] cand;
      cand    = '0;
      gnt_idx = '0;
      gnt_vld = 1'b0;
      // An out-of-range 'last' behaves like the highest index, so index 0 is searched first.
      base = (last >= 3'(N_SRC)) ? 4'(N_SRC - 1) : {1'b0, last};
      for (int off = 1; off <= N_SRC; off++) begin
         cand = base + 4'(off);
         if (cand >= 4'(N_SRC)) cand = cand - 4'(N_SRC);
         for (int j = 0; j < N_SRC; j++) begin
            if (!gnt_vld && (cand == 4'(j)) && req[j]) begin
               gnt_vld = 1'b1;
               gnt_idx = 3'(j);
            end
         end
      end
   end

endmodule

// File: rtl/dpe_pkt_arbiter.sv
// Packet-level round-robin merge of the CPU FIFO and four Ethernet RX streams onto one DPE stream.
// Optional per-source packet/stall counters are built when DPE_ARB_STATS_EN is defined.
//
// state   | meaning
// IDLE    | arbitrate among enabled, valid sources; no beat moves
// XFER    | stream the granted source's packet through the output register until tlast
module dpe_pkt_arbiter
   import dpe_pkg::*;
#(
   parameter  int N_SRC  = DPE_N_SRC,
   parameter  int DATA_W = DPE_DATA_W,
   localparam int KEEP_W = DATA_W / 8
) (
   input  logic                      clk,
   input  logic                      arst_n,
   input  logic [N_SRC-1:0]          src_en,
   input  logic [N_SRC*DATA_W-1:0]   s_tdata,
   input  logic [N_SRC*KEEP_W-1:0]   s_tkeep,
   input  logic [N_SRC-1:0]          s_tvalid,
   input  logic [N_SRC-1:0]          s_tlast,
   output logic [N_SRC-1:0]          s_tready,
   output logic [DATA_W-1:0]         m_tdata,
   output logic [KEEP_W-1:0]         m_tkeep,
   output logic                      m_tvalid,
   output logic                      m_tlast,
   input  logic                      m_tready,
   output logic [2:0]                m_tsrc,
   output logic                      busy
`ifdef DPE_ARB_STATS_EN
   ,
   input  logic                      stat_clr,
   output logic [N_SRC*32-1:0]       stat_pkt_cnt,
   output logic [N_SRC*32-1:0]       stat_stall_cnt
`endif
);

   arb_state_e        state_q, state_d;
   dpe_src_t          grant_q, grant_d;
   dpe_src_t          last_grant_q, last_grant_d;
   logic [DATA_W-1:0] m_tdata_q, m_tdata_d;
   logic [KEEP_W-1:0] m_tkeep_q, m_tkeep_d;
   logic              m_tvalid_q, m_tvalid_d;
   logic              m_tlast_q, m_tlast_d;
   dpe_src_t          m_tsrc_q, m_tsrc_d;

   logic [N_SRC-1:0]  req;
   logic [2:0]        pick_idx;
   logic              pick_vld;
   logic              out_ready;
   logic              accept;
   logic [N_SRC-1:0]  s_tready_c;
   logic [DATA_W-1:0] sel_tdata;
   logic [KEEP_W-1:0] sel_tkeep;
   logic              sel_tvalid;
   logic              sel_tlast;

   assign req       = s_tvalid & src_en;
   assign out_ready = !m_tvalid_q || m_tready;

   rr_arbiter #(
      .N_SRC (N_SRC)
   ) u_rr (
      .req     (req),
      .last    (last_grant_q),
      .gnt_idx (pick_idx),
      .gnt_vld (pick_vld)
   );

   always_comb begin
      sel_tdata  = '0;
      sel_tkeep  = '0;
      sel_tvalid = 1'b0;
      sel_tlast  = 1'b0;
      for (int i = 0; i < N_SRC; i++) begin
         if (grant_q == dpe_src_t'(i)) begin
            sel_tdata  = s_tdata[i*DATA_W +: DATA_W];
            sel_tkeep  = s_tkeep[i*KEEP_W +: KEEP_W];
            sel_tvalid = s_tvalid[i];
            sel_tlast  = s_tlast[i];
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      m_tdata_d    = m_tdata_q;
      m_tkeep_d    = m_tkeep_q;
      m_tlast_d    = m_tlast_q;
      m_tsrc_d     = m_tsrc_q;
      m_tvalid_d   = m_tvalid_q && !m_tready;
      s_tready_c   = '0;
      accept       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (pick_vld) begin
               grant_d = pick_idx;
               state_d = ST_XFER;
            end
         end
         ST_XFER: begin
            for (int i = 0; i < N_SRC; i++) begin
               s_tready_c[i] = (grant_q == dpe_src_t'(i)) && out_ready;
            end
            accept = sel_tvalid && out_ready;
            if (accept) begin
               m_tdata_d  = sel_tdata;
               m_tkeep_d  = sel_tkeep;
               m_tlast_d  = sel_tlast;
               m_tsrc_d   = grant_q;
               m_tvalid_d = 1'b1;
               // Priority only rotates once the whole packet has gone through.
               if (sel_tlast) begin
                  last_grant_d = grant_q;
                  state_d      = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q      <= ST_IDLE;
         grant_q      <= '0;
         last_grant_q <= dpe_src_t'(N_SRC - 1);
         m_tdata_q    <= '0;
         m_tkeep_q    <= '0;
         m_tvalid_q   <= 1'b0;
         m_tlast_q    <= 1'b0;
         m_tsrc_q     <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         m_tdata_q    <= m_tdata_d;
         m_tkeep_q    <= m_tkeep_d;
         m_tvalid_q   <= m_tvalid_d;
         m_tlast_q    <= m_tlast_d;
         m_tsrc_q     <= m_tsrc_d;
      end
   end

   assign s_tready = s_tready_c;
   assign m_tdata  = m_tdata_q;
   assign m_tkeep  = m_tkeep_q;
   assign m_tvalid = m_tvalid_q;
   assign m_tlast  = m_tlast_q;
   assign m_tsrc   = m_tsrc_q;
   assign busy     = (state_q == ST_XFER);

`ifdef DPE_ARB_STATS_EN
   logic [N_SRC*32-1:0] pkt_cnt_q, pkt_cnt_d;
   logic [N_SRC*32-1:0] stall_cnt_q, stall_cnt_d;

   // A clear wins over a same-cycle increment.
   always_comb begin
      pkt_cnt_d   = pkt_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (stat_clr) begin
         pkt_cnt_d   = '0;
         stall_cnt_d = '0;
      end else begin
         for (int i = 0; i < N_SRC; i++) begin
            pkt_cnt_d[i*32 +: 32] = pkt_cnt_q[i*32 +: 32]
               + 32'(accept && sel_tlast && (grant_q == dpe_src_t'(i)));
            stall_cnt_d[i*32 +: 32] = stall_cnt_q[i*32 +: 32]
               + 32'(s_tvalid[i] && src_en[i] && !s_tready_c[i]);
         end
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         pkt_cnt_q   <= '0;
         stall_cnt_q <= '0;
      end else begin
         pkt_cnt_q   <= pkt_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stat_pkt_cnt   = pkt_cnt_q;
   assign stat_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dpe_pkt_arbiter.sv
// Directed self-checking bench for dpe_pkt_arbiter; DPE_ARB_STATS_EN also exercises the counters.
module tb_dpe_pkt_arbiter;
   import dpe_pkg::*;

   logic         clk = 1'b0;
   logic         arst_n = 1'b1;
   logic [4:0]   src_en = '0;
   logic [319:0] s_tdata = '0;
   logic [39:0]  s_tkeep = '0;
   logic [4:0]   s_tvalid = '0;
   logic [4:0]   s_tlast = '0;
   logic [4:0]   s_tready;
   logic [63:0]  m_tdata;
   logic [7:0]   m_tkeep;
   logic         m_tvalid;
   logic         m_tlast;
   logic         m_tready = 1'b0;
   logic [2:0]   m_tsrc;
   logic         busy;
`ifdef DPE_ARB_STATS_EN
   logic         stat_clr = 1'b0;
   logic [159:0] stat_pkt_cnt;
   logic [159:0] stat_stall_cnt;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dpe_pkt_arbiter dut (
      .clk      (clk),
      .arst_n   (arst_n),
      .src_en   (src_en),
      .s_tdata  (s_tdata),
      .s_tkeep  (s_tkeep),
      .s_tvalid (s_tvalid),
      .s_tlast  (s_tlast),
      .s_tready (s_tready),
      .m_tdata  (m_tdata),
      .m_tkeep  (m_tkeep),
      .m_tvalid (m_tvalid),
      .m_tlast  (m_tlast),
      .m_tready (m_tready),
      .m_tsrc   (m_tsrc),
      .busy     (busy)
`ifdef DPE_ARB_STATS_EN
      ,
      .stat_clr       (stat_clr),
      .stat_pkt_cnt   (stat_pkt_cnt),
      .stat_stall_cnt (stat_stall_cnt)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_src(input int i, input logic [63:0] d, input logic l, input logic v,
                            input logic [7:0] k);
      s_tdata[i*64 +: 64] = d;
      s_tkeep[i*8 +: 8]   = k;
      s_tlast[i]          = l;
      s_tvalid[i]         = v;
   endtask

   task automatic idle_all();
      s_tvalid = '0;
      s_tlast  = '0;
      s_tdata  = '0;
      s_tkeep  = '0;
   endtask

   task automatic do_reset();
      arst_n = 1'b0;
      idle_all();
      m_tready = 1'b1;
      src_en   = 5'h1F;
`ifdef DPE_ARB_STATS_EN
      stat_clr = 1'b0;
`endif
      tick();
      tick();
      #2 arst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      src_en   = 5'h1F;
      s_tvalid = 5'h1F;
      m_tready = 1'b1;
      #2 arst_n = 1'b0;
      #1;
      checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got %b exp 0", m_tvalid); end
      checks++; if (m_tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast got %b exp 0", m_tlast); end
      checks++; if (m_tdata !== 64'h0) begin errors++; $display("FAIL rst_tdata got %h exp 0", m_tdata); end
      checks++; if (m_tkeep !== 8'h0) begin errors++; $display("FAIL rst_tkeep got %h exp 0", m_tkeep); end
      checks++; if (m_tsrc !== 3'd0) begin errors++; $display("FAIL rst_tsrc got %0d exp 0", m_tsrc); end
      checks++; if (s_tready !== 5'b0) begin errors++; $display("FAIL rst_s_tready got %b exp 0", s_tready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
      tick();
      tick();
      checks++; if (busy !== 1'b0 || m_tvalid !== 1'b0) begin errors++; $display("FAIL rst_held busy %b tvalid %b exp 0 0", busy, m_tvalid); end
   endtask

   task automatic test_basic();
      do_reset();
      drive_src(2, 64'hA0, 1'b0, 1'b1, 8'hFF);
      tick();
      checks++; if (busy !== 1'b1 || m_tvalid !== 1'b0) begin errors++; $display("FAIL basic_arb busy %b tvalid %b exp 1 0", busy, m_tvalid); end
      checks++; if (s_tready !== 5'b00100) begin errors++; $display("FAIL basic_ready got %b exp 00100", s_tready); end
      tick();
      checks++; if (m_tvalid !== 1'b1 || m_tdata !== 64'hA0 || m_tsrc !== 3'd2) begin errors++; $display("FAIL basic_beat0 v %b d %h src %0d exp 1 a0 2", m_tvalid, m_tdata, m_tsrc); end
      drive_src(2, 64'hA1, 1'b0, 1'b1, 8'hFF);
      tick();
      checks++; if (m_tdata !== 64'hA1 || m_tsrc !== 3'd2 || m_tlast !== 1'b0) begin errors++; $display("FAIL basic_beat1 d %h src %0d last %b exp a1 2 0", m_tdata, m_tsrc, m_tlast); end
      drive_src(2, 64'hA2, 1'b1, 1'b1, 8'h0F);
      tick();
      checks++; if (m_tdata !== 64'hA2 || m_tlast !== 1'b1 || m_tkeep !== 8'h0F || m_tsrc !== 3'd2) begin errors++; $display("FAIL basic_beat2 d %h last %b keep %h src %0d exp a2 1 0f 2", m_tdata, m_tlast, m_tkeep, m_tsrc); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_drop got %b exp 0", busy); end
      drive_src(2, 64'h0, 1'b0, 1'b0, 8'h00);
      tick();
      checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL basic_drain got %b exp 0", m_tvalid); end
   endtask

   task automatic test_round_robin();
      do_reset();
      for (int i = 0; i < 5; i++) drive_src(i, 64'hB0 + 64'(i), 1'b1, 1'b1, 8'hFF);
      for (int k = 0; k < 10; k++) begin
         tick();
         checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rr_bubble%0d got %b exp 0", k, m_tvalid); end
         tick();
         checks++; if (m_tvalid !== 1'b1 || m_tsrc !== 3'(k % 5) || m_tdata !== 64'hB0 + 64'(k % 5)) begin errors++; $display("FAIL rr_pkt%0d v %b src %0d d %h exp 1 %0d %h", k, m_tvalid, m_tsrc, m_tdata, k % 5, 64'hB0 + 64'(k % 5)); end
         if (k == 9) idle_all();
      end
      tick();
      checks++; if (busy !== 1'b0 || m_tvalid !== 1'b0) begin errors++; $display("FAIL rr_end busy %b v %b exp 0 0", busy, m_tvalid); end
   endtask

   task automatic test_backpressure();
      do_reset();
      drive_src(1, 64'hC0, 1'b0, 1'b1, 8'hFF);
      drive_src(3, 64'hD0, 1'b1, 1'b1, 8'hFF);
      tick();
      checks++; if (s_tready !== 5'b00010) begin errors++; $display("FAIL bp_grant got %b exp 00010", s_tready); end
      tick();
      checks++; if (m_tdata !== 64'hC0 || m_tsrc !== 3'd1) begin errors++; $display("FAIL bp_c0 d %h src %0d exp c0 1", m_tdata, m_tsrc); end
      drive_src(1, 64'hC1, 1'b0, 1'b1, 8'hFF);
      tick();
      checks++; if (m_tdata !== 64'hC1) begin errors++; $display("FAIL bp_c1 got %h exp c1", m_tdata); end
      drive_src(1, 64'hC2, 1'b0, 1'b1, 8'hFF);
      m_tready = 1'b0;
      #1;
      checks++; if (s_tready !== 5'b00000) begin errors++; $display("FAIL bp_stall_ready got %b exp 0", s_tready); end
      tick();
      checks++; if (m_tvalid !== 1'b1 || m_tdata !== 64'hC1) begin errors++; $display("FAIL bp_hold1 v %b d %h exp 1 c1", m_tvalid, m_tdata); end
      tick();
      checks++; if (m_tvalid !== 1'b1 || m_tdata !== 64'hC1 || m_tsrc !== 3'd1) begin errors++; $display("FAIL bp_hold2 v %b d %h src %0d exp 1 c1 1", m_tvalid, m_tdata, m_tsrc); end
      m_tready = 1'b1;
      #1;
      checks++; if (s_tready !== 5'b00010) begin errors++; $display("FAIL bp_resume_ready got %b exp 00010", s_tready); end
      tick();
      checks++; if (m_tdata !== 64'hC2) begin errors++; $display("FAIL bp_c2 got %h exp c2", m_tdata); end
      drive_src(1, 64'hC3, 1'b1, 1'b1, 8'hFF);
      tick();
      checks++; if (m_tdata !== 64'hC3 || m_tlast !== 1'b1 || m_tsrc !== 3'd1) begin errors++; $display("FAIL bp_c3 d %h last %b src %0d exp c3 1 1", m_tdata, m_tlast, m_tsrc); end
      drive_src(1, 64'h0, 1'b0, 1'b0, 8'h00);
      tick();
      checks++; if (m_tvalid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL bp_bubble v %b busy %b exp 0 1", m_tvalid, busy); end
      tick();
      checks++; if (m_tdata !== 64'hD0 || m_tsrc !== 3'd3 || m_tlast !== 1'b1) begin errors++; $display("FAIL bp_d0 d %h src %0d last %b exp d0 3 1", m_tdata, m_tsrc, m_tlast); end
      drive_src(3, 64'h0, 1'b0, 1'b0, 8'h00);
      tick();
   endtask

   task automatic test_mask();
      do_reset();
      src_en = 5'b10110;
      for (int i = 0; i < 5; i++) drive_src(i, 64'hE0 + 64'(i), (i != 2), 1'b1, 8'hFF);
      tick();
      tick();
      checks++; if (m_tsrc !== SRC_ETH1 || m_tdata !== 64'hE1) begin errors++; $display("FAIL mask_first src %0d d %h exp 1 e1", m_tsrc, m_tdata); end
      tick();
      checks++; if (s_tready !== 5'b00100) begin errors++; $display("FAIL mask_grant2 got %b exp 00100", s_tready); end
      tick();
      checks++; if (m_tsrc !== SRC_ETH2 || m_tdata !== 64'hE2 || m_tlast !== 1'b0) begin errors++; $display("FAIL mask_src2_b0 src %0d d %h last %b exp 2 e2 0", m_tsrc, m_tdata, m_tlast); end
      src_en = 5'b10010;
      drive_src(2, 64'hF2, 1'b1, 1'b1, 8'hFF);
      tick();
      checks++; if (m_tsrc !== SRC_ETH2 || m_tdata !== 64'hF2 || m_tlast !== 1'b1) begin errors++; $display("FAIL mask_src2_b1 src %0d d %h last %b exp 2 f2 1", m_tsrc, m_tdata, m_tlast); end
      for (int k = 0; k < 4; k++) begin
         tick();
         tick();
         checks++; if (m_tvalid !== 1'b1 || m_tsrc !== ((k % 2 == 0) ? SRC_ETH4 : SRC_ETH1)) begin errors++; $display("FAIL mask_seq%0d v %b src %0d exp 1 %0d", k, m_tvalid, m_tsrc, (k % 2 == 0) ? 4 : 1); end
         if (k == 3) idle_all();
      end
      src_en = 5'b00000;
      for (int i = 0; i < 5; i++) drive_src(i, 64'h90 + 64'(i), 1'b1, 1'b1, 8'hFF);
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++; if (busy !== 1'b0 || m_tvalid !== 1'b0) begin errors++; $display("FAIL mask_all%0d busy %b v %b exp 0 0", k, busy, m_tvalid); end
      end
      src_en = 5'h1F;
      tick();
      tick();
      checks++; if (m_tsrc !== SRC_ETH2 || m_tdata !== 64'h92) begin errors++; $display("FAIL mask_lastgrant src %0d d %h exp 2 92", m_tsrc, m_tdata); end
      idle_all();
      tick();
   endtask

   task automatic test_reset_midpacket();
      do_reset();
      drive_src(4, 64'h40, 1'b0, 1'b1, 8'hFF);
      tick();
      tick();
      drive_src(4, 64'h41, 1'b0, 1'b1, 8'hFF);
      tick();
      checks++; if (m_tdata !== 64'h41 || busy !== 1'b1) begin errors++; $display("FAIL rmid_beat2 d %h busy %b exp 41 1", m_tdata, busy); end
      arst_n = 1'b0;
      #1;
      checks++; if (m_tvalid !== 1'b0 || m_tdata !== 64'h0 || m_tsrc !== 3'd0 || busy !== 1'b0 || s_tready !== 5'b0 || m_tkeep !== 8'h0 || m_tlast !== 1'b0) begin errors++; $display("FAIL rmid_async v %b d %h src %0d busy %b rdy %b exp all 0", m_tvalid, m_tdata, m_tsrc, busy, s_tready); end
      drive_src(0, 64'h50, 1'b1, 1'b1, 8'hFF);
      drive_src(4, 64'h54, 1'b1, 1'b1, 8'hFF);
      #2 arst_n = 1'b1;
      tick();
      checks++; if (busy !== 1'b1 || m_tvalid !== 1'b0) begin errors++; $display("FAIL rmid_arb busy %b v %b exp 1 0", busy, m_tvalid); end
      tick();
      checks++; if (m_tsrc !== SRC_CPU || m_tdata !== 64'h50) begin errors++; $display("FAIL rmid_tie src %0d d %h exp 0 50", m_tsrc, m_tdata); end
      drive_src(0, 64'h0, 1'b0, 1'b0, 8'h00);
      tick();
      tick();
      checks++; if (m_tsrc !== SRC_ETH4 || m_tdata !== 64'h54) begin errors++; $display("FAIL rmid_next src %0d d %h exp 4 54", m_tsrc, m_tdata); end
      idle_all();
      tick();
   endtask

`ifdef DPE_ARB_STATS_EN
   task automatic test_stats();
      do_reset();
      drive_src(3, 64'h33, 1'b1, 1'b1, 8'hFF);
      for (int k = 0; k < 10; k++) begin
         tick();
         tick();
      end
      checks++; if (stat_pkt_cnt[3*32 +: 32] !== 32'd10) begin errors++; $display("FAIL stats_pkt10 got %0d exp 10", stat_pkt_cnt[3*32 +: 32]); end
      checks++; if (stat_pkt_cnt[0 +: 32] !== 32'd0) begin errors++; $display("FAIL stats_pkt_src0 got %0d exp 0", stat_pkt_cnt[0 +: 32]); end
      tick();
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      checks++; if (m_tsrc !== SRC_ETH3 || m_tlast !== 1'b1) begin errors++; $display("FAIL stats_11th src %0d last %b exp 3 1", m_tsrc, m_tlast); end
      checks++; if (stat_pkt_cnt[3*32 +: 32] !== 32'd0) begin errors++; $display("FAIL stats_clr got %0d exp 0", stat_pkt_cnt[3*32 +: 32]); end
      idle_all();
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_round_robin();
      test_backpressure();
      test_mask();
      test_reset_midpacket();
`ifdef DPE_ARB_STATS_EN
      test_stats();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
